// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared constants and types for the memory-mapped UART TX. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  // Word offsets, decoded from addr[3:2]
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [15:0] UART_DEFAULT_DIV = 16'd434;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // A programmed divisor of zero behaves as one clock per bit
  function automatic logic [15:0] eff_div(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo: single-clock FIFO, power-of-two depth, first-word fall-through. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // Full is judged on pre-edge state, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ----------------------------------------------------------------------------
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  addr,
  input  logic [31:0] d,
  input  logic [3:0]  we,
  output logic [31:0] q,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    reg_sel;
  logic          push;
  logic          pop;
  logic          ovf_clr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic [15:0]   div;
  logic [15:0]   div_eff;
  logic          overflow;
  logic [31:0]   status;
  logic [31:0]   rd_data;
  logic          unused_bits;

  tx_state_e   state, state_next;
  logic [7:0]  shreg, shreg_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [15:0] baud_cnt, baud_next;
  logic [15:0] frame_div, frame_div_next;
  logic        tx_next;
  logic        bit_end;

  assign reg_sel     = addr[3:2];
  assign push        = en && (reg_sel == UART_TXDATA) && we[0];
  assign ovf_clr     = en && (reg_sel == UART_STATUS) && we[0] && d[ST_OVF];
  assign div_eff     = eff_div(div);
  assign unused_bits = ^{addr[1:0], d[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (d[7:0]),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_comb begin
    status                      = '0;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_BUSY]             = (state != S_IDLE);
    status[ST_OVF]              = overflow;
    status[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      UART_STATUS: rd_data = status;
      UART_DIV:    rd_data = {16'd0, div};
      default:     rd_data = '0;
    endcase
  end

  // Bus side: registered read data, divisor and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      div      <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (en) begin
        q <= (we == 4'd0) ? rd_data : 32'd0;
        if (reg_sel == UART_DIV) begin
          if (we[0]) div[7:0]  <= d[7:0];
          if (we[1]) div[15:8] <= d[15:8];
        end
      end
      if (push && fifo_full) overflow <= 1'b1;
      else if (ovf_clr)      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
      frame_div <= 16'd1;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bit_idx   <= bit_idx_next;
      baud_cnt  <= baud_next;
      frame_div <= frame_div_next;
      tx        <= tx_next;
    end
  end

  assign bit_end = (baud_cnt == 16'd0);

  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    bit_idx_next   = bit_idx;
    baud_next      = baud_cnt;
    frame_div_next = frame_div;
    pop            = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop            = 1'b1;
          state_next     = S_START;
          shreg_next     = fifo_head;
          frame_div_next = div_eff;
          baud_next      = div_eff - 16'd1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next   = S_DATA;
          bit_idx_next = 3'd0;
          baud_next    = frame_div - 16'd1;
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_next = frame_div - 16'd1;
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = shreg >> 1;
          end
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued
          if (!fifo_empty) begin
            pop            = 1'b1;
            state_next     = S_START;
            shreg_next     = fifo_head;
            frame_div_next = div_eff;
            baud_next      = div_eff - 16'd1;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          baud_next = baud_cnt - 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_mmio;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] d    = 32'd0;
  logic [3:0]  we   = 4'h0;
  logic [31:0] q;
  logic        tx;

  int          total  = 0;
  int          passed = 0;
  int          failed = 0;
  logic [31:0] rdv;
  int          lows;

  uart_tx_mmio #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .addr (addr),
    .d    (d),
    .we   (we),
    .q    (q),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] v, input logic [3:0] be);
    en = 1'b1; addr = a; d = v; we = be;
    tick();
    en = 1'b0; we = 4'h0; d = 32'd0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] v);
    en = 1'b1; addr = a; we = 4'h0;
    tick();
    en = 1'b0;
    v = q;
  endtask

  // Expected line level i cycles after the start-bit edge of a frame
  function automatic logic exp_tx(input logic [7:0] b, input int div, input int i);
    int k;
    k = i / div;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic frame_chk(input logic [7:0] b, input int div, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      tick();
      check($sformatf("tx_%02h_i%0d", b, i), {31'd0, tx}, {31'd0, exp_tx(b, div, i)});
    end
  endtask

  task automatic frame_rx(input logic [7:0] b, input int div, input int bound);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    check($sformatf("start_%02h", b), {31'd0, tx}, 32'd0);
    frame_chk(b, div, 1, 10*div - 1);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_q", q, 32'd0);
    bus_rd(4'h4, rdv);
    check("rst_status", rdv, 32'h0000_0002);

    // Single frame 0x55 at DIV=4
    bus_wr(4'h0, 32'h55, 4'b0001);
    check("tx_idle_at_push", {31'd0, tx}, 32'd1);
    frame_chk(8'h55, 4, 0, 39);
    tick();
    check("idle_after_55", {31'd0, tx}, 32'd1);
    bus_rd(4'h4, rdv);
    check("status_after_55", rdv, 32'h0000_0002);

    // Three back-to-back frames at DIV=2
    bus_wr(4'h8, 32'd2, 4'b0011);
    bus_wr(4'h0, 32'hA0, 4'b0001);
    bus_wr(4'h0, 32'h0F, 4'b0001);
    check("a0_i0", {31'd0, tx}, {31'd0, exp_tx(8'hA0, 2, 0)});
    bus_rd(4'h4, rdv);
    check("a0_i1", {31'd0, tx}, {31'd0, exp_tx(8'hA0, 2, 1)});
    check("status_busy_cnt1", rdv, 32'h0000_0104);
    bus_wr(4'h0, 32'hFF, 4'b0001);
    check("a0_i2", {31'd0, tx}, {31'd0, exp_tx(8'hA0, 2, 2)});
    frame_chk(8'hA0, 2, 3, 19);
    frame_chk(8'h0F, 2, 0, 19);
    frame_chk(8'hFF, 2, 0, 19);
    tick();
    check("idle_after_b2b", {31'd0, tx}, 32'd1);

    // Overflow: one long frame in flight, then ten pushes into an 8-deep FIFO
    bus_wr(4'h8, 32'd20, 4'b0011);
    bus_wr(4'h0, 32'hFF, 4'b0001);
    for (int k = 1; k <= 10; k++) bus_wr(4'h0, k, 4'b0001);
    bus_rd(4'h4, rdv);
    check("status_full_ovf", rdv, 32'h0000_080D);
    bus_wr(4'h4, 32'h8, 4'b0001);
    bus_rd(4'h4, rdv);
    check("status_ovf_clr", rdv, 32'h0000_0805);
    bus_wr(4'h8, 32'd2, 4'b0011);
    repeat (20) tick();
    for (int k = 1; k <= 8; k++) frame_rx(8'(k), 2, (k == 1) ? 400 : 4);
    lows = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (tx === 1'b0) lows++;
    end
    check("no_dropped_frames", lows, 32'd0);
    bus_rd(4'h4, rdv);
    check("status_drained", rdv, 32'h0000_0002);

    // DIV change mid-frame applies to the next frame only; DIV=0 acts as 1
    bus_wr(4'h8, 32'd8, 4'b0011);
    bus_wr(4'h0, 32'h3C, 4'b0001);
    bus_wr(4'h0, 32'hC3, 4'b0001);
    check("3c_i0", {31'd0, tx}, {31'd0, exp_tx(8'h3C, 8, 0)});
    bus_wr(4'h8, 32'd3, 4'b0011);
    check("3c_i1", {31'd0, tx}, {31'd0, exp_tx(8'h3C, 8, 1)});
    bus_rd(4'h8, rdv);
    check("3c_i2", {31'd0, tx}, {31'd0, exp_tx(8'h3C, 8, 2)});
    check("div_read_3", rdv, 32'h0000_0003);
    frame_chk(8'h3C, 8, 3, 79);
    frame_chk(8'hC3, 3, 0, 29);
    bus_wr(4'h8, 32'd0, 4'b0011);
    check("idle_before_div0", {31'd0, tx}, 32'd1);
    bus_wr(4'h0, 32'h5A, 4'b0001);
    frame_chk(8'h5A, 1, 0, 9);
    tick();
    check("idle_after_div0", {31'd0, tx}, 32'd1);

    // Reset during DATA bit 4 with a second byte queued
    bus_wr(4'h8, 32'd4, 4'b0011);
    bus_wr(4'h0, 32'h00, 4'b0001);
    bus_wr(4'h0, 32'h11, 4'b0001);
    check("00_i0", {31'd0, tx}, {31'd0, exp_tx(8'h00, 4, 0)});
    frame_chk(8'h00, 4, 1, 21);
    rst = 1'b1;
    tick();
    check("tx_after_rst", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    bus_rd(4'h4, rdv);
    check("status_after_rst", rdv, 32'h0000_0002);
    bus_rd(4'h8, rdv);
    check("div_after_rst", rdv, 32'h0000_0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data-memory port, downstream of the core's dmem interface. Software stores bytes to TXDATA; they queue in a FIFO and are serialised 8N1, LSB first, on `tx`. Reads return status or divisor with the one-cycle latency the core's MEM stage expects, so no stall is needed. The system address decoder drives `en` only for this block's window.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: TX FIFO entries. Must be a power of two and at least 2.
- `DEFAULT_DIV`, 16'd434: bit period in clocks after reset (50 MHz / 115200).

Ports:
- `clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `en`, in, 1: access strobe, 1-cycle pulse from the core's EXEC state.
- `addr`, in, 4: byte offset in the window. Only `addr[3:2]` is decoded.
- `d`, in, 32: write data.
- `we`, in, 4: byte write enables. All zero with `en` means a read.
- `q`, out, 32: registered read data.
- `tx`, out, 1: serial output, idle high.

## Operation
- Register map (word offset → register):
  - 0x0 TXDATA: write with `we[0]` pushes `d[7:0]`. Reads return 0.
  - 0x4 STATUS (read):
    - bit0: full.
    - bit1: empty.
    - bit2: busy (serialiser not IDLE).
    - bit3: overflow, sticky.
    - bits[15:8]: FIFO count.
    - all other bits 0.
  - 0x4 STATUS (write): `we[0]` with `d[3]=1` clears overflow. Other bits are ignored.
  - 0x8 DIV: 16-bit divisor. Write bytes with `we[1:0]`. Reads return it zero-extended. A stored value of 0 is used as 1.
  - 0xC: reads 0, writes ignored.
- Push to TXDATA while full: the byte is dropped and overflow is set. Full is sampled before any same-cycle pop, so the push is dropped even if the serialiser pops in that cycle.
- Serialiser FSM:
  - IDLE → START when the FIFO is not empty. The head is popped into the shift register and DIV is latched for the whole frame.
  - START → DATA after one bit period.
  - DATA → STOP after 8 bit periods, LSB first.
  - STOP → START directly if the FIFO is not empty (back-to-back, no idle gap), otherwise STOP → IDLE.
- `tx` value per state: 1 in IDLE and STOP, 0 in START, current data bit in DATA.
- A DIV write mid-frame affects only the next frame.
- Count rules: push only → +1; pop only → −1; accepted push with simultaneous pop → unchanged. The count never exceeds `FIFO_DEPTH`. FIFO pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values:
  - `q` = 0, `tx` = 1.
  - FSM IDLE, FIFO empty, overflow 0, DIV = `DEFAULT_DIV`.
  - Asserting `rst` mid-frame aborts the frame: `tx` is 1 the cycle after the reset edge and queued bytes are discarded.
- Read latency:
  - `q` updates on the edge that samples `en`, and is valid in the following cycle (the core's MEM stage).
  - `q` holds its value when `en` is low.
  - A write access sets `q` to 0.
- Push at edge E:
  - The FIFO is non-empty after E.
  - If IDLE, the pop and IDLE→START happen at edge E+1, so `tx` falls after E+1.
- Frame length is exactly 10×DIV clocks from the falling start-bit edge to the end of the stop bit. Back-to-back frames have exactly 10×DIV spacing.
- STATUS read in the same cycle as a push or pop returns pre-edge state.
- Bit timing uses a down-counter loaded with DIV−1 at each bit start. The bit advances when the counter reaches 0.

## Structure
- Package `uart_pkg`:
  - register offsets (`UART_TXDATA`, `UART_STATUS`, `UART_DIV`);
  - STATUS bit positions;
  - serialiser state encoding (IDLE, START, DATA, STOP, 2 bits);
  - default divisor constant.
- Sub-module `sync_fifo`, parameterised width/depth:
  - inputs `push`/`pop`;
  - outputs `full`/`empty`/`count`/`head`;
  - same clock and reset as this block.
- Bus decode, registers and serialiser FSM live in the top module.

## Test plan
- Reset with DIV=4: `tx`=1, `q`=0. STATUS read returns 0x00000002 (empty only).
- Write 0x55 to 0x0 with DIV=4: `tx` falls one cycle after the write edge, then emits 0,1,0,1,0,1,0,1,0,1 at 4 clocks per bit, then idle high. STATUS afterwards is 0x00000002.
- Push 0xA0, 0x0F, 0xFF back-to-back with DIV=2: three contiguous frames of 20 clocks each with no idle gap. A STATUS read after the second push shows busy=1 and count=1.
- FIFO_DEPTH=8: push 10 bytes while IDLE is blocked by a long DIV. Count saturates at 8 and overflow=1, and only the first 8 bytes appear on `tx`. Write 0x8 to STATUS: overflow=0.
- Write DIV=0x0003 mid-frame at DIV=8: the current frame finishes at 8 clocks per bit and the next frame uses 3. A DIV read returns 0x00000003. Writing 0 gives 1-clock bits.
- Assert `rst` during DATA bit 4: `tx`=1 the next cycle. STATUS reads 0x00000002 and DIV reads `DEFAULT_DIV`.
